// File: rtl/uart_host_ctrl.sv
// Polling host controller for a register-mapped UART: reads the status register,
// pushes upstream bytes into the TX FIFO and pulls received bytes into a valid/ready stream.
module uart_host_ctrl #(
  parameter int STROBE_LEN = 3,
  parameter int POLL_GAP   = 15,
  parameter int TX_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_err,
  input  logic        rx_ready,
  output logic        sr_read,
  output logic        tx_write,
  output logic        rx_read,
  output logic [31:0] tdr,
  input  logic [31:0] sr,
  input  logic [31:0] rdr,
  output logic        ovr_sticky,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  // Byte streams use valid/ready: a byte moves on a clock where both are high;
  // the source holds valid and data stable until then.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POLL    = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    SETTLE  = 3'd4,
    DELIVER = 3'd5,
    WAIT    = 3'd6
  } state_t;

  localparam logic [3:0] STB_LAST   = 4'(STROBE_LEN - 1);
  localparam logic [3:0] STB_DEC    = 4'(STROBE_LEN);
  localparam logic [3:0] SETTLE_END = 4'd2;
  localparam logic [7:0] GAP_LAST   = 8'(POLL_GAP - 1);
  localparam logic [4:0] CRED_FULL  = 5'(TX_DEPTH);

  state_t      state, state_next;
  logic [3:0]  stb_cnt;
  logic [7:0]  gap_cnt;
  logic [4:0]  credits;
  logic        cap_rdy;
  logic        cap_err;
  logic        after_write;
  logic        can_write;
  logic        unused_bits;

  assign unused_bits = ^{sr[31:17], sr[14], sr[7:0], rdr[31:8]};

  assign can_write = tx_valid && (credits != 5'd0);

  assign sr_read   = (state == POLL) && (stb_cnt < STB_DEC);
  assign tx_write  = (state == WRITE);
  assign rx_read   = (state == READ);
  assign tx_ready  = (state == WRITE) && (stb_cnt == 4'd0);
  assign rx_valid  = (state == DELIVER);
  assign busy      = (state != IDLE) && (state != WAIT);
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = POLL;
      POLL: begin
        // Status was captured on the last strobe clock; this is the decision clock.
        if (stb_cnt == STB_DEC) begin
          if (cap_rdy && !rx_valid) state_next = READ;
          else if (can_write)       state_next = WRITE;
          else                      state_next = WAIT;
        end
      end
      WRITE:   if (stb_cnt == STB_LAST) state_next = SETTLE;
      READ:    if (stb_cnt == STB_LAST) state_next = SETTLE;
      SETTLE: begin
        if (stb_cnt == SETTLE_END) begin
          if (!after_write)   state_next = DELIVER;
          else if (can_write) state_next = WRITE;
          else                state_next = POLL;
        end
      end
      DELIVER: if (rx_ready) state_next = POLL;
      WAIT:    if (gap_cnt == GAP_LAST) state_next = POLL;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      stb_cnt     <= 4'd0;
      gap_cnt     <= 8'd0;
      credits     <= CRED_FULL;
      cap_rdy     <= 1'b0;
      cap_err     <= 1'b0;
      after_write <= 1'b0;
      tdr         <= 32'h0;
      rx_data     <= 8'h00;
      rx_err      <= 1'b0;
      ovr_sticky  <= 1'b0;
    end else begin
      state <= state_next;

      if (state_next != state)
        stb_cnt <= 4'd0;
      else if ((state == POLL || state == WRITE || state == READ || state == SETTLE)
               && stb_cnt != 4'hF)
        stb_cnt <= stb_cnt + 4'd1;

      if (state == WAIT && state_next == WAIT) gap_cnt <= gap_cnt + 8'd1;
      else                                     gap_cnt <= 8'd0;

      // POLL never issues a tx_write, so a captured FIFO-empty flag always refills credits.
      if (state == POLL && stb_cnt == STB_LAST) begin
        cap_rdy <= sr[8];
        cap_err <= sr[10] | sr[11] | sr[12] | sr[15];
        if (sr[9] || sr[16]) ovr_sticky <= 1'b1;
        if (sr[13])          credits    <= CRED_FULL;
      end

      // The byte is latched on entry so tdr is valid on the first tx_write clock.
      if (state_next == WRITE && state != WRITE)
        tdr <= {24'h0, tx_data};

      if (state == WRITE && stb_cnt == 4'd0 && credits != 5'd0)
        credits <= credits - 5'd1;

      if (state == READ && stb_cnt == 4'd0) begin
        rx_data <= rdr[7:0];
        rx_err  <= cap_err;
      end

      if (state == WRITE) after_write <= 1'b1;
      if (state == READ)  after_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Directed bench for uart_host_ctrl: a vector table of single-poll scenarios plus
// hand sequences for backpressure, mid-strobe reset, credit exhaustion and overrun.
module tb_uart_host_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_err;
  logic        rx_ready = 1'b1;
  logic        sr_read, tx_write, rx_read;
  logic [31:0] tdr;
  logic [31:0] sr = 32'h0;
  logic [31:0] rdr = 32'h0;
  logic        ovr_sticky, busy;
  logic [2:0]  state_dbg;

  uart_host_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .rx_ready(rx_ready),
    .sr_read(sr_read), .tx_write(tx_write), .rx_read(rx_read),
    .tdr(tdr), .sr(sr), .rdr(rdr),
    .ovr_sticky(ovr_sticky), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check / scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  int          cyc, sr_rises, rise1, rise2, wr_w, rd_w, ready_cnt, multi, stab_err, tw_rises;
  int          strobe_cnt, bytes_left;
  logic        wr_done, rd_done, tdr_got, rx_got, prev_sr, prev_tw;
  logic [31:0] first_tdr, wr_tdr;
  logic [7:0]  first_rx, next_byte;
  logic        first_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; sr_rises = 0; rise1 = 0; rise2 = 0; wr_w = 0; rd_w = 0; ready_cnt = 0;
    multi = 0; stab_err = 0; tw_rises = 0; strobe_cnt = 0;
    wr_done = 0; rd_done = 0; tdr_got = 0; rx_got = 0; prev_sr = 0; prev_tw = 0;
    first_tdr = 32'h0; wr_tdr = 32'h0; first_rx = 8'h00; first_err = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic offer(input int n, input logic [7:0] b0);
    exp_q.delete();
    bytes_left = n;
    next_byte  = b0;
    tx_data    = b0;
    tx_valid   = (n > 0);
    if (n > 0) exp_q.push_back(b0);
  endtask

  // One clock: sample on the falling edge, then update the upstream driver.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (sr_read && !prev_sr) begin
      sr_rises++;
      if (sr_rises == 1) rise1 = cyc;
      if (sr_rises == 2) rise2 = cyc;
    end
    if (tx_write) begin
      if (!wr_done) wr_w++;
    end else if (wr_w > 0) wr_done = 1;
    if (rx_read) begin
      if (!rd_done) rd_w++;
    end else if (rd_w > 0) rd_done = 1;
    if (tx_write && !prev_tw) begin
      tw_rises++;
      wr_tdr = tdr;
      if (!tdr_got) begin first_tdr = tdr; tdr_got = 1; end
      if (exp_q.size() == 0) check("tdr_sb_underrun", 32'd1, 32'd0);
      else check("tdr_sb", tdr, {24'h0, exp_q.pop_front()});
    end
    if ((state_dbg == 3'd2 || state_dbg == 3'd4) && tdr !== wr_tdr && tw_rises > 0) stab_err++;
    if (int'(sr_read) + int'(tx_write) + int'(rx_read) > 1) multi++;
    if (tx_write || rx_read) strobe_cnt++;
    if (rx_valid && !rx_got) begin first_rx = rx_data; first_err = rx_err; rx_got = 1; end
    if (tx_ready) ready_cnt++;
    if (tx_ready && tx_valid) begin
      bytes_left--;
      if (bytes_left > 0) begin
        next_byte = next_byte + 8'd1;
        tx_data   = next_byte;
        exp_q.push_back(next_byte);
      end else tx_valid = 1'b0;
    end
    prev_sr = sr_read;
    prev_tw = tx_write;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    clear_stats();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] sr;
    logic [31:0] rdr;
    int          n_bytes;
    logic [7:0]  byte0;
    int          rise2;
    int          wr_w;
    logic [31:0] tdr_exp;
    int          rd_w;
    logic [7:0]  rx_exp;
    logic        err_exp;
    logic        ovr_exp;
    int          ready_exp;
  } vec_t;

  localparam int NV = 10;
  localparam int WIN = 38;
  vec_t vecs[NV];

  initial begin
    //             sr            rdr           n  b0     r2  wr tdr           rd rx     err   ovr   rdy
    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 0, 8'h00, 20, 0, 32'h0000_0000, 0, 8'h00, 1'b0, 1'b0, 0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000, 1, 8'hA5, 11, 3, 32'h0000_00A5, 0, 8'h00, 1'b0, 1'b0, 1};
    vecs[2] = '{32'h0000_2000, 32'h0000_0000, 2, 8'h5A, 17, 3, 32'h0000_005A, 0, 8'h00, 1'b0, 1'b0, 2};
    vecs[3] = '{32'h0000_0900, 32'h0000_003C, 0, 8'h00, 12, 0, 32'h0000_0000, 3, 8'h3C, 1'b1, 1'b0, 0};
    vecs[4] = '{32'h0000_0200, 32'h0000_0000, 0, 8'h00, 20, 0, 32'h0000_0000, 0, 8'h00, 1'b0, 1'b1, 0};
    vecs[5] = '{32'h0001_0000, 32'h0000_0000, 0, 8'h00, 20, 0, 32'h0000_0000, 0, 8'h00, 1'b0, 1'b1, 0};
    vecs[6] = '{32'h0000_8100, 32'hFFFF_FF81, 0, 8'h00, 12, 0, 32'h0000_0000, 3, 8'h81, 1'b1, 1'b0, 0};
    vecs[7] = '{32'h0000_2100, 32'h0000_0042, 0, 8'h00, 12, 0, 32'h0000_0000, 3, 8'h42, 1'b0, 1'b0, 0};
    vecs[8] = '{32'h0000_0100, 32'h0000_0011, 1, 8'h77, 12, 0, 32'h0000_0000, 3, 8'h11, 1'b0, 1'b0, 0};
    vecs[9] = '{32'h0000_1500, 32'h0000_00E7, 0, 8'h00, 12, 0, 32'h0000_0000, 3, 8'hE7, 1'b1, 1'b0, 0};
  end

  // ---------------- test body ----------------
  initial begin
    clear_stats();
    offer(0, 8'h00);

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    check("rst_sr_read", {31'h0, sr_read}, 32'd0);
    check("rst_tx_write", {31'h0, tx_write}, 32'd0);
    check("rst_rx_read", {31'h0, rx_read}, 32'd0);
    check("rst_tx_ready", {31'h0, tx_ready}, 32'd0);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_tdr", tdr, 32'h0);
    check("rst_rx_data", {24'h0, rx_data}, 32'h0);
    check("rst_rx_err", {31'h0, rx_err}, 32'd0);
    check("rst_ovr", {31'h0, ovr_sticky}, 32'd0);
    check("rst_state", {29'h0, state_dbg}, 32'd0);

    // Table-driven single-window scenarios
    for (int i = 0; i < NV; i++) begin
      sr = vecs[i].sr;
      rdr = vecs[i].rdr;
      rx_ready = 1'b1;
      rst_n = 1'b0;
      offer(vecs[i].n_bytes, vecs[i].byte0);
      do_reset();
      for (int c = 0; c < WIN; c++) step();
      if (!tdr_got) first_tdr = tdr;
      if (!rx_got) begin first_rx = rx_data; first_err = rx_err; end
      check($sformatf("v%0d_rise1", i), rise1, 1);
      check($sformatf("v%0d_rise2", i), rise2, vecs[i].rise2);
      check($sformatf("v%0d_wr_width", i), wr_w, vecs[i].wr_w);
      check($sformatf("v%0d_tdr", i), first_tdr, vecs[i].tdr_exp);
      check($sformatf("v%0d_rd_width", i), rd_w, vecs[i].rd_w);
      check($sformatf("v%0d_rx_data", i), {24'h0, first_rx}, {24'h0, vecs[i].rx_exp});
      check($sformatf("v%0d_rx_err", i), {31'h0, first_err}, {31'h0, vecs[i].err_exp});
      check($sformatf("v%0d_ovr", i), {31'h0, ovr_sticky}, {31'h0, vecs[i].ovr_exp});
      check($sformatf("v%0d_ready_cycles", i), ready_cnt, vecs[i].ready_exp);
      check($sformatf("v%0d_multi_strobe", i), multi, 0);
      check($sformatf("v%0d_tdr_stable", i), stab_err, 0);
    end

    // Overrun stays sticky after status clears; busy drops in WAIT
    sr = 32'h0000_0200;
    offer(0, 8'h00);
    do_reset();
    step(); step();
    check("ovr_busy_poll", {31'h0, busy}, 32'd1);
    step();
    check("ovr_before_capture", {31'h0, ovr_sticky}, 32'd0);
    for (int c = 0; c < 5; c++) step();
    sr = 32'h0;
    check("ovr_busy_wait", {31'h0, busy}, 32'd0);
    for (int c = 0; c < 25; c++) step();
    check("ovr_sticky_hold", {31'h0, ovr_sticky}, 32'd1);

    // Backpressure: rx_valid held, no strobes while the consumer stalls
    sr = 32'h0000_0900;
    rdr = 32'h0000_003C;
    rx_ready = 1'b0;
    offer(0, 8'h00);
    do_reset();
    begin
      int budget = 50;
      while (!rx_valid && budget > 0) begin step(); budget--; end
      check("bp_rx_valid_seen", {31'h0, rx_valid}, 32'd1);
    end
    check("bp_rd_width", rd_w, 3);
    check("bp_rx_data", {24'h0, rx_data}, 32'h3C);
    check("bp_rx_err", {31'h0, rx_err}, 32'd1);
    strobe_cnt = 0;
    sr_rises = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (!rx_valid || rx_data !== 8'h3C || rx_err !== 1'b1) stab_err++;
    end
    check("bp_no_strobes", strobe_cnt + sr_rises, 0);
    check("bp_rx_stable", stab_err, 0);
    rx_ready = 1'b1;
    step();
    check("bp_rx_valid_drop", {31'h0, rx_valid}, 32'd0);
    check("bp_repoll", {31'h0, sr_read}, 32'd1);

    // Reset during the second tx_write clock
    sr = 32'h0;
    rdr = 32'h0;
    offer(2, 8'hC3);
    do_reset();
    begin
      int budget = 20;
      while (!tx_write && budget > 0) begin step(); budget--; end
      check("mid_write_seen", {31'h0, tx_write}, 32'd1);
    end
    step();
    check("mid_write_second_clock", {31'h0, tx_write}, 32'd1);
    rst_n = 1'b0;
    step();
    check("mid_rst_tx_write", {31'h0, tx_write}, 32'd0);
    check("mid_rst_busy", {31'h0, busy}, 32'd0);
    check("mid_rst_tdr", tdr, 32'h0);

    // Credits restored to 16: 17 bytes with FIFO never empty -> 16 writes
    offer(17, 8'h10);
    do_reset();
    for (int c = 0; c < 140; c++) step();
    check("cred_writes", tw_rises, 16);
    check("cred_bytes_left", bytes_left, 1);
    check("cred_multi_strobe", multi, 0);
    sr = 32'h0000_2000;
    for (int c = 0; c < 45; c++) step();
    check("refill_writes", tw_rises, 17);
    check("refill_bytes_left", bytes_left, 0);
    check("refill_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
